// File: rtl/prefetch_pkg.sv
// Shared types, defaults and helpers for the instruction prefetch unit.
package prefetch_pkg;

    localparam int          DEFAULT_XLEN     = 32;
    localparam int          DEFAULT_DEPTH    = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FETCH_STRIDE     = 32'd4;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Occupancy/credit counters must be able to hold the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/prefetch_if.sv
// Memory request/response and decode channels of the prefetch unit.
interface prefetch_if
    import prefetch_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) ();

    logic            imem_req_valid_o;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_req_ready_i;
    logic            imem_rsp_valid_i;
    logic [XLEN-1:0] imem_rsp_data_i;
    logic            instr_valid_o;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            instr_ready_i;

    modport master (
        output imem_req_valid_o,
        output imem_req_addr_o,
        input  imem_req_ready_i,
        input  imem_rsp_valid_i,
        input  imem_rsp_data_i,
        output instr_valid_o,
        output instr_o,
        output instr_pc_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_valid_o,
        input  imem_req_addr_o,
        output imem_req_ready_i,
        output imem_rsp_valid_i,
        output imem_rsp_data_i,
        input  instr_valid_o,
        input  instr_o,
        input  instr_pc_o,
        output instr_ready_i
    );

endinterface

// File: rtl/prefetch_fifo.sv
// Power-of-two prefetch buffer with synchronous flush; push and pop may coincide.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int WIDTH = 2 * DEFAULT_XLEN,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head_data,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // Storage is not reset; the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: credit-limited fetch into a tagged buffer, with redirect/debug flush.
// Optional performance counters are built when PREFETCH_PERF_EN is defined.
module prefetch_unit
    import prefetch_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter int              DEPTH    = DEFAULT_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            pc_wr_debug_i,
    input  logic [XLEN-1:0] pc_debug_i,
    prefetch_if.master      bus,
    output logic [31:0]     perf_fetched_o,
    output logic [31:0]     perf_flushed_o
);

    localparam int              CW          = cnt_width(DEPTH);
    localparam logic [CW:0]     DEPTH_LIMIT = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] STRIDE      = XLEN'(FETCH_STRIDE);

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_next;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] rsp_pc_next;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_cnt_next;

    logic            flush_evt;
    logic [XLEN-1:0] flush_pc;
    logic [CW:0]     credit_used;
    logic            req_valid;
    logic            req_fire;
    logic            rsp_accept;
    logic            instr_pop;

    logic [2*XLEN-1:0] fifo_head;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    // Debug PC writes only take effect while halted; redirect has priority.
    assign flush_evt   = redirect_i | (pc_wr_debug_i & ~run);
    assign flush_pc    = redirect_i ? redirect_pc_i : pc_debug_i;
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign req_valid   = (state == RUN) && run && !flush_evt && (credit_used < DEPTH_LIMIT);
    assign req_fire    = req_valid && bus.imem_req_ready_i;
    assign rsp_accept  = bus.imem_rsp_valid_i && (state != FLUSH) && !flush_evt;
    assign instr_pop   = !fifo_empty && bus.instr_ready_i;

    prefetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_evt),
        .push      (rsp_accept),
        .push_data ({rsp_pc, bus.imem_rsp_data_i}),
        .pop       (instr_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HALT;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            rsp_pc      <= rsp_pc_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
        end
    end

    // rsp_pc tracks the PC of the next in-order response, so entries need no tag queue.
    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        rsp_pc_next      = rsp_pc;
        outstanding_next = outstanding;
        drop_cnt_next    = drop_cnt;

        if (req_fire) begin
            fetch_pc_next = fetch_pc + STRIDE;
        end
        if (rsp_accept) begin
            rsp_pc_next = rsp_pc + STRIDE;
        end

        case ({req_fire, bus.imem_rsp_valid_i})
            2'b10:   outstanding_next = outstanding + CW'(1);
            2'b01:   outstanding_next = outstanding - CW'(1);
            default: outstanding_next = outstanding;
        endcase

        case (state)
            HALT: begin
                if (run) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!run) begin
                    state_next = HALT;
                end
            end
            FLUSH: begin
                if (bus.imem_rsp_valid_i && (drop_cnt != '0)) begin
                    drop_cnt_next = drop_cnt - CW'(1);
                end
                if ((drop_cnt == '0) || ((drop_cnt == CW'(1)) && bus.imem_rsp_valid_i)) begin
                    state_next = run ? RUN : HALT;
                end
            end
            default: state_next = HALT;
        endcase

        // A response landing in the flush cycle is already counted out of outstanding_next.
        if (flush_evt) begin
            fetch_pc_next = flush_pc;
            rsp_pc_next   = flush_pc;
            drop_cnt_next = outstanding_next;
            if (outstanding_next != '0) begin
                state_next = FLUSH;
            end else begin
                state_next = run ? RUN : HALT;
            end
        end
    end

    assign bus.imem_req_valid_o = req_valid;
    assign bus.imem_req_addr_o  = fetch_pc;
    assign bus.instr_valid_o    = !fifo_empty;
    assign bus.instr_o          = fifo_empty ? '0 : fifo_head[XLEN-1:0];
    assign bus.instr_pc_o       = fifo_empty ? '0 : fifo_head[2*XLEN-1:XLEN];

`ifdef PREFETCH_PERF_EN
    logic        rsp_drop;
    logic [31:0] flushed_inc;
    logic [31:0] fetched_cnt;
    logic [31:0] flushed_cnt;

    assign rsp_drop = bus.imem_rsp_valid_i && ((state == FLUSH) || flush_evt);

    // Entries popped in the flush cycle reach decode, so they are not counted as discarded.
    always_comb begin
        flushed_inc = '0;
        if (flush_evt) begin
            flushed_inc = 32'(fifo_count) - 32'(instr_pop);
        end
        if (rsp_drop) begin
            flushed_inc = flushed_inc + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_cnt <= '0;
            flushed_cnt <= '0;
        end else begin
            fetched_cnt <= fetched_cnt + 32'(instr_pop);
            flushed_cnt <= flushed_cnt + flushed_inc;
        end
    end

    assign perf_fetched_o = fetched_cnt;
    assign perf_flushed_o = flushed_cnt;
`else
    assign perf_fetched_o = '0;
    assign perf_flushed_o = '0;
`endif

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed scoreboard bench for prefetch_unit with a variable-latency in-order memory model.
module tb_prefetch_unit;
    import prefetch_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        pc_wr_debug_i;
    logic [31:0] pc_debug_i;
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_flushed_o;

    prefetch_if #(.XLEN(XLEN)) bus ();

    prefetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .pc_wr_debug_i  (pc_wr_debug_i),
        .pc_debug_i     (pc_debug_i),
        .bus            (bus),
        .perf_fetched_o (perf_fetched_o),
        .perf_flushed_o (perf_flushed_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          req_count = 0;
    int          mem_lat = 1;
    int          cyc = 0;
    logic [31:0] model_pc = 32'h0;
    int          exp_fetched = 0;
    int          exp_flushed = 0;
    exp_t        exp_q[$];
    pend_t       pend_q[$];
    exp_t        e;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] rd_pc,
                                 input logic dbg, input logic [31:0] dbg_pc, input logic irdy);
        run               = r;
        redirect_i        = rd;
        redirect_pc_i     = rd_pc;
        pc_wr_debug_i     = dbg;
        pc_debug_i        = dbg_pc;
        bus.instr_ready_i = irdy;
    endtask

    task automatic wait_for_req(input string tag, input int budget);
        int n;
        n = 0;
        #2;
        while (!bus.imem_req_valid_o && n < budget) begin
            @(posedge clk);
            #3;
            n++;
        end
        checkOutput({tag, "_req_seen"}, 32'(bus.imem_req_valid_o), 32'd1);
    endtask

    task automatic wait_req_count(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (req_count < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, "_req_count"}, 32'(req_count), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_state"},     32'(dut.state), 32'(HALT));
        checkOutput({tag, "_req_valid"}, 32'(bus.imem_req_valid_o), 32'd0);
        checkOutput({tag, "_req_addr"},  bus.imem_req_addr_o, 32'h0);
        checkOutput({tag, "_ivalid"},    32'(bus.instr_valid_o), 32'd0);
        checkOutput({tag, "_instr"},     bus.instr_o, 32'h0);
        checkOutput({tag, "_instr_pc"},  bus.instr_pc_o, 32'h0);
        checkOutput({tag, "_perf_f"},    perf_fetched_o, 32'h0);
        checkOutput({tag, "_perf_x"},    perf_flushed_o, 32'h0);
    endtask

    task automatic check_perf(input string tag);
        checkOutput({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
`ifdef PREFETCH_PERF_EN
        checkOutput({tag, "_perf_fetched"}, perf_fetched_o, 32'(exp_fetched));
        checkOutput({tag, "_perf_flushed"}, perf_flushed_o, 32'(exp_flushed));
`else
        checkOutput({tag, "_perf_fetched"}, perf_fetched_o, 32'h0);
        checkOutput({tag, "_perf_flushed"}, perf_flushed_o, 32'h0);
`endif
    endtask

    // In-order memory: accepts at the handshake edge, answers mem_lat edges later; reset empties it.
    always begin
        @(negedge clk);
        if (reset) begin
            pend_q.delete();
        end else if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
            pend_q.push_back('{addr: bus.imem_req_addr_o, due: cyc + mem_lat});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            bus.imem_rsp_valid_i = 1'b1;
            bus.imem_rsp_data_i  = mem_data(pend_q[0].addr);
            void'(pend_q.pop_front());
        end else begin
            bus.imem_rsp_valid_i = 1'b0;
            bus.imem_rsp_data_i  = '0;
        end
    end

    // Scoreboard: requests are predicted from the model PC, decode pops are compared in order.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            model_pc    = 32'h0;
            exp_fetched = 0;
            exp_flushed = 0;
        end else begin
            if (bus.instr_valid_o && bus.instr_ready_i) begin
                if (exp_q.size() == 0) begin
                    checkOutput("pop_without_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("instr_pc", bus.instr_pc_o, e.pc);
                    checkOutput("instr", bus.instr_o, e.data);
                    exp_fetched++;
                end
            end
            if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
                checkOutput("req_addr", bus.imem_req_addr_o, model_pc);
                exp_q.push_back('{pc: model_pc, data: mem_data(model_pc)});
                model_pc = model_pc + 32'd4;
                req_count++;
            end
            if (redirect_i || (pc_wr_debug_i && !run)) begin
                exp_flushed += exp_q.size();
                exp_q.delete();
                model_pc = redirect_i ? redirect_pc_i : pc_debug_i;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int target;
        reset                = 1'b1;
        bus.imem_req_ready_i = 1'b1;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = '0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick(2);
        reset = 1'b0;
        #2;
        check_reset_outputs("reset");

        $display("[TB] basic streaming fetch");
        run = 1'b1;
        tick();
        #2;
        checkOutput("first_req_valid", 32'(bus.imem_req_valid_o), 32'd1);
        checkOutput("first_req_addr", bus.imem_req_addr_o, 32'h0);
        tick();
        #2;
        checkOutput("ivalid_one_cycle", 32'(bus.instr_valid_o), 32'd0);
        tick();
        #2;
        checkOutput("ivalid_two_cycles", 32'(bus.instr_valid_o), 32'd1);
        checkOutput("first_instr_pc", bus.instr_pc_o, 32'h0);
        tick(6);
        run = 1'b0;
        tick(4);
        #2;
        checkOutput("halt_no_req", 32'(bus.imem_req_valid_o), 32'd0);
        check_perf("stream");

        $display("[TB] credit limit with stalled decode");
        bus.instr_ready_i = 1'b0;
        target = req_count;
        run = 1'b1;
        tick(10);
        #2;
        checkOutput("credit_req_total", 32'(req_count - target), 32'd4);
        checkOutput("credit_req_blocked", 32'(bus.imem_req_valid_o), 32'd0);
        checkOutput("credit_ivalid", 32'(bus.instr_valid_o), 32'd1);
        bus.instr_ready_i = 1'b1;
        tick();
        bus.instr_ready_i = 1'b0;
        tick(2);
        #2;
        checkOutput("credit_after_pop", 32'(req_count - target), 32'd5);
        checkOutput("credit_reblocked", 32'(bus.imem_req_valid_o), 32'd0);

        $display("[TB] redirect with buffered and outstanding fetches");
        mem_lat = 3;
        target = req_count + 2;
        bus.instr_ready_i = 1'b1;
        tick(2);
        bus.instr_ready_i = 1'b0;
        wait_req_count("redir_setup", target, 8);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        #2;
        checkOutput("redir_req_suppressed", 32'(bus.imem_req_valid_o), 32'd0);
        tick();
        redirect_i = 1'b0;
        #2;
        checkOutput("redir_state_flush", 32'(dut.state), 32'(FLUSH));
        tick();
        #2;
        checkOutput("redir_still_flush", 32'(dut.state), 32'(FLUSH));
        checkOutput("redir_no_req_in_flush", 32'(bus.imem_req_valid_o), 32'd0);
        tick();
        #2;
        checkOutput("redir_state_run", 32'(dut.state), 32'(RUN));
        checkOutput("redir_req_valid", 32'(bus.imem_req_valid_o), 32'd1);
        checkOutput("redir_req_addr", bus.imem_req_addr_o, 32'h100);
        mem_lat = 1;
        bus.instr_ready_i = 1'b1;
        tick(8);
        run = 1'b0;
        tick(4);
        #2;
        check_perf("redirect");

        $display("[TB] debug PC load and redirect priority");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        wait_for_req("dbg", 6);
        checkOutput("dbg_req_addr", bus.imem_req_addr_o, 32'h80);
        tick(3);
        run = 1'b0;
        tick(4);
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        wait_for_req("prio", 6);
        checkOutput("prio_req_addr", bus.imem_req_addr_o, 32'h200);
        tick(3);
        run = 1'b0;
        tick(4);

        $display("[TB] fetch PC wraparound");
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        wait_for_req("wrap", 6);
        checkOutput("wrap_req_top", bus.imem_req_addr_o, 32'hFFFF_FFFC);
        tick();
        #2;
        checkOutput("wrap_req_valid", 32'(bus.imem_req_valid_o), 32'd1);
        checkOutput("wrap_req_zero", bus.imem_req_addr_o, 32'h0);
        tick(3);
        run = 1'b0;
        tick(4);
        #2;
        check_perf("wrap");

        $display("[TB] reset during activity");
        mem_lat = 3;
        bus.instr_ready_i = 1'b0;
        target = req_count + 4;
        run = 1'b1;
        wait_req_count("busy_setup", target, 10);
        tick();
        #2;
        checkOutput("busy_ivalid", 32'(bus.instr_valid_o), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        check_reset_outputs("midreset");
        mem_lat = 1;
        bus.instr_ready_i = 1'b1;
        tick(8);
        run = 1'b0;
        tick(4);
        #2;
        check_perf("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
